zion_riscv_fetch_redirect: RTL and testbench
============================================

Name: zion_riscv_fetch_redirect

Overview:
- Fetch-side consumer of the branch/jump execute results: owns the architectural fetch PC and issues sequential instruction-memory requests.
- Accepts the redirect (taken flag plus target address) produced by the execute stage and steers fetch to the target.
- Discards every response that is in flight at the time of a redirect.
- Buffers returned instructions, tagged with their PC, for the decode stage; raises an instruction-address-misaligned exception on a bad target.

Parameters:
- RV64, 0, 1 selects a 64-bit core; address width AW = 32*(RV64+1).
- RESET_PC, 0, fetch PC loaded at reset; must be 4-byte aligned.
- MAX_OUTSTANDING, 2, total credits shared by in-flight requests and instruction-buffer entries (minimum 1, maximum 8).

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset; asynchronous assert, active-low.
- i_bj_en  input  2  branch/jump enable from execute; a redirect occurs when either bit is 1.
- i_tgt_addr  input  AW  branch/jump target; sampled only when a redirect occurs.
- o_req_vld  output  1  instruction fetch request valid.
- o_req_addr  output  AW  fetch address (current PC).
- i_req_rdy  input  1  memory accepts the request.
- i_rsp_vld  input  1  response valid; responses return in order, one per accepted request.
- i_rsp_data  input  32  instruction word.
- o_inst_vld  output  1  instruction buffer not empty.
- o_inst  output  32  instruction at the buffer head.
- o_inst_pc  output  AW  PC of the buffer head.
- i_inst_rdy  input  1  decode accepts the head entry.
- o_misalign_exc  output  1  one-cycle pulse on a misaligned redirect target.
- o_exc_addr  output  AW  offending target; holds its value until the next exception.

Behaviour:
- Reset values: pc=RESET_PC, state=RUN, live_cnt=0, drop_cnt=0, buffer empty, o_req_vld=0 on the first cycle after reset release, o_inst_vld=0, o_misalign_exc=0, o_exc_addr=0.
- redirect = |i_bj_en.
- Credit rule: o_req_vld = (state==RUN) & ~redirect & (live_cnt + drop_cnt + buf_cnt < MAX_OUTSTANDING).
  - o_req_vld does not depend on i_req_rdy.
  - Because of the credit rule, the buffer can never overflow.
- req_fire = o_req_vld & i_req_rdy:
  - pc <= pc + 4, with wrap-around modulo 2^AW;
  - push the request address into an internal PC queue of depth MAX_OUTSTANDING;
  - live_cnt++.
- Response handling:
  - i_rsp_vld with drop_cnt>0: discard the response, pop the PC queue, drop_cnt--.
  - Otherwise: write {pc queue head, i_rsp_data} into the instruction buffer, pop the PC queue, live_cnt--.
  - i_rsp_vld when live_cnt+drop_cnt==0 is a protocol violation; the block asserts on it in simulation and ignores it.
- Buffer is a FIFO of depth MAX_OUTSTANDING with fall-through-free registered outputs.
  - Pop on o_inst_vld & i_inst_rdy.
  - A response written this cycle is visible on o_inst one cycle later (latency: rsp -> o_inst_vld = 1 cycle).
- Redirect (highest priority, same cycle):
  - Flush the instruction buffer (buf_cnt=0, o_inst_vld=0 next cycle).
  - drop_cnt <= live_cnt + drop_cnt minus 1 if this cycle's response was consumed; live_cnt <= 0.
  - Target aligned (tgt[1:0]==0): pc <= i_tgt_addr, state <= RUN; the first request to the target appears the next cycle, subject to credits.
  - Target misaligned: o_misalign_exc=1 the next cycle, o_exc_addr <= i_tgt_addr, state <= EXC, pc unchanged.
- State machine RUN/EXC:
  - EXC issues no requests.
  - Stale responses continue to drain while in EXC.
  - EXC leaves only on an aligned redirect (trap vector), which goes to RUN.
  - A misaligned redirect while already in EXC re-pulses the exception and updates o_exc_addr.
- Simultaneous redirect + i_inst_rdy: the buffer is flushed; the pop has no further effect.
- Simultaneous redirect + i_rsp_vld: that response is dropped and is not counted in drop_cnt.
- Reset mid-operation: all counters, the PC queue and the buffer clear immediately; responses arriving afterwards are protocol violations.

Test Plan:
1. Reset with RESET_PC=0x100, i_req_rdy=1, single-cycle memory -> requests 0x100, 0x104, 0x108...; o_inst_pc matches the address and o_inst matches memory; never more than 2 credits in use.
2. i_inst_rdy=0 with MAX_OUTSTANDING=2 -> exactly 2 requests, buffer full, o_req_vld=0; after one pop, o_req_vld returns the next cycle.
3. Two requests in flight (0x200, 0x204), then i_bj_en=2'b10 with tgt=0x400 -> both responses discarded, next o_req_addr=0x400, first o_inst_pc=0x400.
4. Redirect to tgt=0x402 -> o_misalign_exc pulses for 1 cycle, o_exc_addr=0x402, no requests; then i_bj_en=2'b01 with tgt=0x800 -> fetch resumes at 0x800.
5. Redirect in the same cycle as a response and a decode pop -> no stale entry ever reaches o_inst; drop_cnt returns to 0.
6. PC=0xFFFFFFFC with RV64=0 -> next request address 0x00000000.

Source files
------------

// File: rtl/zion_riscv_fetch_redirect.sv
// Fetch PC owner: issues sequential instruction requests, follows execute-stage redirects,
// discards responses that were in flight at a redirect and buffers the rest for decode.
module zion_riscv_fetch_redirect #(
    parameter  int unsigned              RV64            = 0,
    localparam int unsigned              AW              = 32 * (RV64 + 1),
    parameter  logic [AW-1:0]            RESET_PC        = '0,
    parameter  int unsigned              MAX_OUTSTANDING = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [1:0]    i_bj_en,
    input  logic [AW-1:0] i_tgt_addr,
    output logic          o_req_vld,
    output logic [AW-1:0] o_req_addr,
    input  logic          i_req_rdy,
    input  logic          i_rsp_vld,
    input  logic [31:0]   i_rsp_data,
    output logic          o_inst_vld,
    output logic [31:0]   o_inst,
    output logic [AW-1:0] o_inst_pc,
    input  logic          i_inst_rdy,
    output logic          o_misalign_exc,
    output logic [AW-1:0] o_exc_addr
);

    localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [CW+1:0] MAX_CREDITS = (CW + 2)'(MAX_OUTSTANDING);

    typedef enum logic {ST_RUN, ST_EXC} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_req_arm;
    logic [AW-1:0]   r_pc;
    logic [CW-1:0]   r_live_cnt;
    logic [CW-1:0]   r_drop_cnt;
    logic [CW-1:0]   r_buf_cnt;
    logic [PW-1:0]   r_pcq_wr;
    logic [PW-1:0]   r_pcq_rd;
    logic [PW-1:0]   r_buf_wr;
    logic [PW-1:0]   r_buf_rd;
    logic [AW-1:0]   r_pcq      [MAX_OUTSTANDING];
    logic [AW-1:0]   r_buf_pc   [MAX_OUTSTANDING];
    logic [31:0]     r_buf_inst [MAX_OUTSTANDING];
    logic            r_exc;
    logic [AW-1:0]   r_exc_addr;

    logic            w_redirect;
    logic            w_tgt_misaligned;
    logic            w_rsp_ok;
    logic            w_rsp_drop;
    logic            w_rsp_live;
    logic            w_rsp_keep;
    logic            w_req_fire;
    logic            w_inst_pop;
    logic [CW+1:0]   w_credit_used;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + PW'(1);
    endfunction

    assign w_redirect       = |i_bj_en;
    assign w_tgt_misaligned = |i_tgt_addr[1:0];
    // A response with nothing in flight is a protocol violation and is ignored.
    assign w_rsp_ok         = i_rsp_vld & ((r_live_cnt != '0) | (r_drop_cnt != '0));
    assign w_rsp_drop       = w_rsp_ok & (r_drop_cnt != '0);
    assign w_rsp_live       = w_rsp_ok & (r_drop_cnt == '0);
    assign w_rsp_keep       = w_rsp_live & ~w_redirect;
    assign w_req_fire       = o_req_vld & i_req_rdy;
    assign w_inst_pop       = o_inst_vld & i_inst_rdy & ~w_redirect;
    assign w_credit_used    = (CW + 2)'(r_live_cnt) + (CW + 2)'(r_drop_cnt) + (CW + 2)'(r_buf_cnt);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: default assignment first so no path leaves the signal unassigned (no latch).
    always_comb begin
        w_state_nxt = r_state;
        if (w_redirect) begin
            w_state_nxt = w_tgt_misaligned ? ST_EXC : ST_RUN;
        end
    end

    always_comb begin
        o_req_vld = r_req_arm & (r_state == ST_RUN) & ~w_redirect & (w_credit_used < MAX_CREDITS);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req_arm  <= 1'b0;
            r_pc       <= RESET_PC;
            r_live_cnt <= '0;
            r_drop_cnt <= '0;
            r_buf_cnt  <= '0;
            r_pcq_wr   <= '0;
            r_pcq_rd   <= '0;
            r_buf_wr   <= '0;
            r_buf_rd   <= '0;
            r_exc      <= 1'b0;
            r_exc_addr <= '0;
        end else begin
            r_req_arm <= 1'b1;
            r_exc     <= w_redirect & w_tgt_misaligned;
            if (w_req_fire) r_pcq_wr <= ptr_inc(r_pcq_wr);
            if (w_rsp_ok)   r_pcq_rd <= ptr_inc(r_pcq_rd);

            if (w_redirect) begin
                r_live_cnt <= '0;
                r_drop_cnt <= r_live_cnt + r_drop_cnt - CW'(w_rsp_ok);
                r_buf_cnt  <= '0;
                r_buf_wr   <= '0;
                r_buf_rd   <= '0;
                if (w_tgt_misaligned) r_exc_addr <= i_tgt_addr;
                else                  r_pc       <= i_tgt_addr;
            end else begin
                r_live_cnt <= r_live_cnt + CW'(w_req_fire) - CW'(w_rsp_live);
                r_drop_cnt <= r_drop_cnt - CW'(w_rsp_drop);
                r_buf_cnt  <= r_buf_cnt + CW'(w_rsp_keep) - CW'(w_inst_pop);
                if (w_req_fire) r_pc     <= r_pc + AW'(4);
                if (w_rsp_keep) r_buf_wr <= ptr_inc(r_buf_wr);
                if (w_inst_pop) r_buf_rd <= ptr_inc(r_buf_rd);
            end
        end
    end

    // NOTE: storage arrays carry no reset; occupancy counters alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (w_req_fire) r_pcq[r_pcq_wr] <= r_pc;
        if (w_rsp_keep) begin
            r_buf_pc[r_buf_wr]   <= r_pcq[r_pcq_rd];
            r_buf_inst[r_buf_wr] <= i_rsp_data;
        end
    end

    assign o_req_addr     = r_pc;
    assign o_inst_vld     = (r_buf_cnt != '0);
    assign o_inst         = r_buf_inst[r_buf_rd];
    assign o_inst_pc      = r_buf_pc[r_buf_rd];
    assign o_misalign_exc = r_exc;
    assign o_exc_addr     = r_exc_addr;

    a_no_orphan_rsp: assert property (@(posedge clk) disable iff (!rst_n)
        i_rsp_vld |-> ((r_live_cnt != '0) || (r_drop_cnt != '0)));

endmodule

// File: tb/tb_zion_riscv_fetch_redirect.sv
// Directed bench for zion_riscv_fetch_redirect: cycle table for streaming/backpressure,
// hand sequences for redirect, misalignment, flush races, PC wrap and async reset.
module tb_zion_riscv_fetch_redirect;

    logic        clk;
    logic        rst_n;
    logic [1:0]  i_bj_en;
    logic [31:0] i_tgt_addr;
    logic        o_req_vld;
    logic [31:0] o_req_addr;
    logic        i_req_rdy;
    logic        i_rsp_vld;
    logic [31:0] i_rsp_data;
    logic        o_inst_vld;
    logic [31:0] o_inst;
    logic [31:0] o_inst_pc;
    logic        i_inst_rdy;
    logic        o_misalign_exc;
    logic [31:0] o_exc_addr;

    int          n_tests = 0;
    int          n_fail  = 0;
    bit          rsp_en;
    logic [31:0] pend[$];

    zion_riscv_fetch_redirect #(
        .RV64            (0),
        .RESET_PC        (32'h100),
        .MAX_OUTSTANDING (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_bj_en        (i_bj_en),
        .i_tgt_addr     (i_tgt_addr),
        .o_req_vld      (o_req_vld),
        .o_req_addr     (o_req_addr),
        .i_req_rdy      (i_req_rdy),
        .i_rsp_vld      (i_rsp_vld),
        .i_rsp_data     (i_rsp_data),
        .o_inst_vld     (o_inst_vld),
        .o_inst         (o_inst),
        .o_inst_pc      (o_inst_pc),
        .i_inst_rdy     (i_inst_rdy),
        .o_misalign_exc (o_misalign_exc),
        .o_exc_addr     (o_exc_addr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, summary not reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ 32'hA5A5_0013;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock: records an accepted request, then the memory model answers in order one cycle later.
    task automatic step();
        bit          fire;
        logic [31:0] a;
        fire = o_req_vld && i_req_rdy;
        a    = o_req_addr;
        @(posedge clk);
        if (fire) pend.push_back(a);
        #1;
        if (rsp_en && pend.size() > 0) begin
            i_rsp_vld  = 1'b1;
            i_rsp_data = mem(pend.pop_front());
        end else begin
            i_rsp_vld  = 1'b0;
            i_rsp_data = '0;
        end
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        i_bj_en   = 2'b00;
        i_rsp_vld = 1'b0;
        pend.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic        inst_rdy;
        logic        e_req_vld;
        logic [31:0] e_req_addr;
        logic        e_inst_vld;
        logic [31:0] e_inst_pc;
    } vec_t;

    vec_t vecs[13];

    initial begin
        vecs = '{
            '{1'b1, 1'b0, 32'h100, 1'b0, 32'h0},
            '{1'b1, 1'b1, 32'h100, 1'b0, 32'h0},
            '{1'b1, 1'b1, 32'h104, 1'b0, 32'h0},
            '{1'b1, 1'b0, 32'h108, 1'b1, 32'h100},
            '{1'b1, 1'b1, 32'h108, 1'b1, 32'h104},
            '{1'b1, 1'b1, 32'h10C, 1'b0, 32'h0},
            '{1'b1, 1'b0, 32'h110, 1'b1, 32'h108},
            '{1'b0, 1'b1, 32'h110, 1'b1, 32'h10C},
            '{1'b0, 1'b0, 32'h114, 1'b1, 32'h10C},
            '{1'b0, 1'b0, 32'h114, 1'b1, 32'h10C},
            '{1'b1, 1'b0, 32'h114, 1'b1, 32'h10C},
            '{1'b0, 1'b1, 32'h114, 1'b1, 32'h110},
            '{1'b0, 1'b0, 32'h118, 1'b1, 32'h110}
        };

        rst_n      = 1'b0;
        i_bj_en    = 2'b00;
        i_tgt_addr = '0;
        i_req_rdy  = 1'b1;
        i_rsp_vld  = 1'b0;
        i_rsp_data = '0;
        i_inst_rdy = 1'b1;
        rsp_en     = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset req_vld", o_req_vld, 0);
        check("reset inst_vld", o_inst_vld, 0);
        check("reset exc", o_misalign_exc, 0);
        check("reset exc_addr", o_exc_addr, 0);
        check("reset req_addr", o_req_addr, 32'h100);
        rst_n = 1'b1;

        // Streaming with a single-cycle memory, then decode backpressure filling the buffer.
        for (int i = 0; i < 13; i++) begin
            i_inst_rdy = vecs[i].inst_rdy;
            #1;
            check($sformatf("vec%0d req_vld", i), o_req_vld, vecs[i].e_req_vld);
            check($sformatf("vec%0d req_addr", i), o_req_addr, vecs[i].e_req_addr);
            check($sformatf("vec%0d inst_vld", i), o_inst_vld, vecs[i].e_inst_vld);
            check($sformatf("vec%0d exc", i), o_misalign_exc, 0);
            if (vecs[i].e_inst_vld) begin
                check($sformatf("vec%0d inst_pc", i), o_inst_pc, vecs[i].e_inst_pc);
                check($sformatf("vec%0d inst", i), o_inst, mem(vecs[i].e_inst_pc));
            end
            step();
        end

        // Redirect with two requests in flight: both stale responses discarded.
        do_reset();
        rsp_en = 1'b0; i_req_rdy = 1'b1; i_inst_rdy = 1'b1;
        i_bj_en = 2'b01; i_tgt_addr = 32'h200; #1;
        check("t3 redirect req_vld", o_req_vld, 0);
        step();
        i_bj_en = 2'b00; #1;
        check("t3 req0 vld", o_req_vld, 1);
        check("t3 req0 addr", o_req_addr, 32'h200);
        step(); #1;
        check("t3 req1 vld", o_req_vld, 1);
        check("t3 req1 addr", o_req_addr, 32'h204);
        step();
        i_bj_en = 2'b10; i_tgt_addr = 32'h400; #1;
        check("t3 full req_vld", o_req_vld, 0);
        rsp_en = 1'b1;
        step();
        i_bj_en = 2'b00; #1;
        check("t3 drain req_vld", o_req_vld, 0);
        check("t3 target addr", o_req_addr, 32'h400);
        check("t3 drain inst_vld0", o_inst_vld, 0);
        step(); #1;
        check("t3 drain inst_vld1", o_inst_vld, 0);
        check("t3 tgt req_vld", o_req_vld, 1);
        check("t3 tgt req_addr", o_req_addr, 32'h400);
        step(); #1;
        check("t3 rsp inst_vld", o_inst_vld, 0);
        step(); #1;
        check("t3 first inst_vld", o_inst_vld, 1);
        check("t3 first inst_pc", o_inst_pc, 32'h400);
        check("t3 first inst", o_inst, mem(32'h400));

        // Misaligned target, re-pulse while in EXC, then trap-vector redirect.
        do_reset();
        rsp_en = 1'b1; i_inst_rdy = 1'b1;
        i_bj_en = 2'b01; i_tgt_addr = 32'h402; #1;
        check("t4 pre exc", o_misalign_exc, 0);
        step();
        i_bj_en = 2'b00; #1;
        check("t4 exc pulse", o_misalign_exc, 1);
        check("t4 exc_addr", o_exc_addr, 32'h402);
        check("t4 exc req_vld", o_req_vld, 0);
        check("t4 pc kept", o_req_addr, 32'h100);
        step();
        i_bj_en = 2'b10; i_tgt_addr = 32'h406; #1;
        check("t4 exc one cycle", o_misalign_exc, 0);
        check("t4 exc hold addr", o_exc_addr, 32'h402);
        step();
        i_bj_en = 2'b00; #1;
        check("t4 repulse", o_misalign_exc, 1);
        check("t4 repulse addr", o_exc_addr, 32'h406);
        check("t4 exc no req", o_req_vld, 0);
        step();
        i_bj_en = 2'b01; i_tgt_addr = 32'h800; #1;
        check("t4 repulse one cycle", o_misalign_exc, 0);
        step();
        i_bj_en = 2'b00; #1;
        check("t4 resume req_vld", o_req_vld, 1);
        check("t4 resume addr", o_req_addr, 32'h800);
        step(); #1;
        step(); #1;
        check("t4 resume inst_vld", o_inst_vld, 1);
        check("t4 resume inst_pc", o_inst_pc, 32'h800);
        rst_n = 1'b0; #1;
        check("t4 async rst exc_addr", o_exc_addr, 0);
        check("t4 async rst inst_vld", o_inst_vld, 0);
        check("t4 async rst req_vld", o_req_vld, 0);

        // Redirect coinciding with a response and a decode pop.
        do_reset();
        rsp_en = 1'b1; i_inst_rdy = 1'b0;
        step(); #1;
        check("t5 req0 addr", o_req_addr, 32'h100);
        check("t5 req0 vld", o_req_vld, 1);
        step(); #1;
        check("t5 req1 addr", o_req_addr, 32'h104);
        step();
        i_inst_rdy = 1'b1; i_bj_en = 2'b01; i_tgt_addr = 32'h300; #1;
        check("t5 head before flush", o_inst_pc, 32'h100);
        check("t5 rsp present", i_rsp_vld, 1);
        step();
        i_bj_en = 2'b00; #1;
        check("t5 flushed inst_vld", o_inst_vld, 0);
        check("t5 req_vld after flush", o_req_vld, 1);
        check("t5 req addr after flush", o_req_addr, 32'h300);
        step(); #1;
        check("t5 no stale inst", o_inst_vld, 0);
        step(); #1;
        check("t5 new inst_vld", o_inst_vld, 1);
        check("t5 new inst_pc", o_inst_pc, 32'h300);
        check("t5 new inst", o_inst, mem(32'h300));
        rst_n = 1'b0; #1;
        check("t5 async rst inst_vld", o_inst_vld, 0);

        // PC wrap at the top of the 32-bit address space.
        do_reset();
        rsp_en = 1'b1; i_inst_rdy = 1'b1;
        i_bj_en = 2'b01; i_tgt_addr = 32'hFFFF_FFFC;
        step();
        i_bj_en = 2'b00; #1;
        check("t6 top addr", o_req_addr, 32'hFFFF_FFFC);
        check("t6 top vld", o_req_vld, 1);
        step(); #1;
        check("t6 wrap addr", o_req_addr, 32'h0000_0000);
        check("t6 wrap vld", o_req_vld, 1);
        step(); #1;
        check("t6 wrap inst_pc", o_inst_pc, 32'hFFFF_FFFC);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
